// File: rtl/clk_edge_strobe.sv
// Resynchronises a slow toggling clock into rise/fall strobes and runs counted bursts of rising
// edges. Define CLK_EDGE_STROBE_WATCHDOG_EN to abort stalled bursts after TIMEOUT idle cycles.
module clk_edge_strobe #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             div_clk_in,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             burst_stb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             stall_err
);

  localparam int unsigned PrimeW = $clog2(SYNC_STAGES + 2);

  typedef enum logic {StIdle, StRun} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [PrimeW-1:0]      r_prime_cnt;
  logic                   w_primed;
  logic                   r_rise;
  logic                   r_fall;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_tick;
  logic [CNT_W-1:0]       w_tick_nxt;
  logic [CNT_W-1:0]       r_len;
  logic [CNT_W-1:0]       w_len_nxt;
  logic                   r_done;
  logic                   w_done_nxt;

  // Until the chain has filled, its contents reflect reset rather than the input.
  assign w_primed = (r_prime_cnt == PrimeW'(SYNC_STAGES + 1));

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync      <= '0;
      r_prev      <= 1'b0;
      r_prime_cnt <= '0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], div_clk_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      if (!w_primed) begin
        r_prime_cnt <= r_prime_cnt + PrimeW'(1);
      end
      r_rise <= w_primed & r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= w_primed & ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

`ifdef CLK_EDGE_STROBE_WATCHDOG_EN
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  logic [StallW-1:0] r_stall_cnt;
  logic [StallW-1:0] w_stall_cnt_nxt;
  logic              r_stall_err;
  logic              w_stall_err_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_len_nxt   = r_len;
    w_done_nxt  = 1'b0;
`ifdef CLK_EDGE_STROBE_WATCHDOG_EN
    w_stall_cnt_nxt = r_stall_cnt;
    w_stall_err_nxt = r_stall_err;
`endif
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_tick_nxt = '0;
          w_len_nxt  = burst_len;
`ifdef CLK_EDGE_STROBE_WATCHDOG_EN
          w_stall_err_nxt = 1'b0;
          w_stall_cnt_nxt = StallW'(1);
`endif
          if (burst_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = StRun;
          end
        end
      end
      StRun: begin
        if (r_rise) begin
          w_tick_nxt = r_tick + CNT_W'(1);
          if (w_tick_nxt == r_len) begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end
        end
`ifdef CLK_EDGE_STROBE_WATCHDOG_EN
        // Counter holds cycles elapsed since the last strobe (or burst start).
        if (r_rise || r_fall) begin
          w_stall_cnt_nxt = StallW'(1);
        end else begin
          w_stall_cnt_nxt = r_stall_cnt + StallW'(1);
          if (w_stall_cnt_nxt == StallW'(TIMEOUT)) begin
            w_state_nxt     = StIdle;
            w_done_nxt      = 1'b1;
            w_stall_err_nxt = 1'b1;
          end
        end
`endif
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_tick  <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
`ifdef CLK_EDGE_STROBE_WATCHDOG_EN
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_len   <= w_len_nxt;
      r_done  <= w_done_nxt;
`ifdef CLK_EDGE_STROBE_WATCHDOG_EN
      r_stall_cnt <= w_stall_cnt_nxt;
      r_stall_err <= w_stall_err_nxt;
`endif
    end
  end

  assign rise_stb  = r_rise;
  assign fall_stb  = r_fall;
  assign busy      = (r_state == StRun);
  assign burst_stb = r_rise & busy;
  assign done      = r_done;
  assign tick_cnt  = r_tick;
`ifdef CLK_EDGE_STROBE_WATCHDOG_EN
  assign stall_err = r_stall_err;
`else
  assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_clk_edge_strobe.sv
// Bench for clk_edge_strobe: random slow clock and bursts against a timestamp-based model.
module tb_clk_edge_strobe;

  localparam int unsigned D  = 2;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 64;
`ifdef CLK_EDGE_STROBE_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic         clk_in     = 1'b0;
  logic         reset_n    = 1'b1;
  logic         div_clk_in = 1'b0;
  logic         start      = 1'b0;
  logic [W-1:0] burst_len  = '0;
  logic         rise_stb, fall_stb, burst_stb, busy, done, stall_err;
  logic [W-1:0] tick_cnt;

  clk_edge_strobe #(
    .SYNC_STAGES(D),
    .CNT_W      (W),
    .TIMEOUT    (TO)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .div_clk_in(div_clk_in),
    .start     (start),
    .burst_len (burst_len),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .burst_stb (burst_stb),
    .busy      (busy),
    .done      (done),
    .tick_cnt  (tick_cnt),
    .stall_err (stall_err)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Slow-clock generator
  int half      = 10;
  int ph        = 0;
  bit run_div   = 1'b0;
  int gen_rises = 0;
  int freeze_at = 0;

  // Reference model: strobes derived from the sample history, burst from timestamps
  int           n      = 0;
  bit           hist_q[$];
  bit           m_rise = 1'b0;
  bit           m_fall = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit           m_stall = 1'b0;
  logic [W-1:0] m_tick = '0;
  logic [W-1:0] m_len  = '0;
  int           m_ref  = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    n = 0;
    hist_q.delete();
    m_rise = 0; m_fall = 0; m_busy = 0; m_done = 0; m_stall = 0;
    m_tick = '0; m_len = '0; m_ref = 0;
  endtask

  task automatic model_edge();
    bit p_busy, p_rise, p_fall, a, b;
    int sz;
    if (!reset_n) begin
      model_reset();
      return;
    end
    p_busy = m_busy; p_rise = m_rise; p_fall = m_fall;
    n++;
    m_done = 0;
    if (!p_busy) begin
      if (start) begin
        m_tick  = '0;
        m_stall = 0;
        m_len   = burst_len;
        if (burst_len == '0) m_done = 1;
        else begin
          m_busy = 1;
          m_ref  = n - 1;
        end
      end
    end else if (p_rise) begin
      m_tick++;
      m_ref = n - 1;
      if (m_tick == m_len) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (p_fall) begin
      m_ref = n - 1;
    end else if (WD && (n - m_ref == TO)) begin
      m_busy  = 0;
      m_done  = 1;
      m_stall = 1;
    end
    hist_q.push_back(div_clk_in);
    if (hist_q.size() > 8) void'(hist_q.pop_front());
    // An input change visible at edge k shows up as a strobe after edge k+D.
    m_rise = 0;
    m_fall = 0;
    if (n >= D + 2) begin
      sz = hist_q.size();
      a  = hist_q[sz-1-D];
      b  = hist_q[sz-2-D];
      m_rise = a & ~b;
      m_fall = ~a & b;
    end
  endtask

  task automatic compare_all(input string tag);
    check_bit({tag, ".rise"},  rise_stb,  m_rise);
    check_bit({tag, ".fall"},  fall_stb,  m_fall);
    check_bit({tag, ".burst"}, burst_stb, m_rise & m_busy);
    check_bit({tag, ".busy"},  busy,      m_busy);
    check_bit({tag, ".done"},  done,      m_done);
    check_bit({tag, ".stall"}, stall_err, m_stall);
    check_int({tag, ".tick"},  int'(tick_cnt), int'(m_tick));
  endtask

  // Entered just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input string tag);
    if (run_div) begin
      ph++;
      if (ph >= half) begin
        ph = 0;
        div_clk_in = ~div_clk_in;
        if (div_clk_in) begin
          gen_rises++;
          if (freeze_at != 0 && gen_rises == freeze_at) run_div = 0;
        end
      end
    end
    @(posedge clk_in);
    cyc++;
    model_edge();
    #1;
    compare_all(tag);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all("rst_async");
  endtask

  initial begin
    int bs, last_stb, done_cyc;
    #1 reset_n = 1'b0;
    @(negedge clk_in);
    repeat (3) cycle("reset");
    reset_n = 1'b1;

    // Square wave, 10 high / 10 low
    run_div = 1; half = 10; ph = 0;
    repeat (120) cycle("square");

    // Level held high through reset release
    do_reset();
    div_clk_in = 1'b1;
    run_div = 0;
    repeat (2) cycle("rst_hi");
    reset_n = 1'b1;
    repeat (12) cycle("hold_hi");
    run_div = 1; half = 10; ph = 0;
    repeat (40) cycle("drop");

    // Burst of 5 with an ignored mid-burst start
    half = 3; ph = 0;
    while (m_busy || m_done) cycle("drain");
    start = 1; burst_len = 5;
    cycle("b5_start");
    start = 0;
    bs = 0;
    for (int i = 0; i < 200; i++) begin
      start     = (i == 7);
      burst_len = W'($urandom);
      cycle("b5");
      start = 0;
      if (burst_stb) bs++;
      if (done) break;
    end
    burst_len = '0;
    check_int("b5_burst_cnt", bs, 5);
    check_int("b5_tick", int'(tick_cnt), 5);
    check_bit("b5_busy", busy, 1'b0);
    cycle("b5_after");

    // Zero-length burst
    start = 1; burst_len = 0;
    cycle("b0_start");
    start = 0;
    check_bit("b0_done", done, 1'b1);
    check_bit("b0_busy", busy, 1'b0);
    repeat (3) cycle("b0_after");

    // Random bursts with random slow-clock periods
    for (int k = 0; k < 6; k++) begin
      half = int'($urandom_range(2, 7));
      start = 1; burst_len = W'($urandom_range(1, 6));
      cycle("rnd_start");
      start = 0;
      for (int i = 0; i < 300; i++) begin
        start = m_busy && ($urandom_range(0, 7) == 0);
        burst_len = W'($urandom);
        cycle("rnd");
        start = 0;
        if (!m_busy) break;
      end
      check_bit("rnd_end_busy", busy, 1'b0);
      repeat (int'($urandom_range(0, 5))) cycle("rnd_gap");
    end

    // Slow clock stops after 3 rising edges of an 8-edge burst
    run_div = 0; div_clk_in = 0;
    repeat (8) cycle("wd_quiet");
    start = 1; burst_len = 8;
    cycle("wd_start");
    start = 0;
    gen_rises = 0; freeze_at = 3; ph = 0; half = 4; run_div = 1;
    last_stb = 0; done_cyc = 0;
    for (int i = 0; i < int'(TO) + 100; i++) begin
      cycle("wd");
      if (rise_stb || fall_stb) last_stb = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    freeze_at = 0;
    check_int("wd_tick", int'(tick_cnt), 3);
`ifdef CLK_EDGE_STROBE_WATCHDOG_EN
    check_int("wd_done_delay", done_cyc - last_stb, int'(TO));
    check_bit("wd_stall_err", stall_err, 1'b1);
    check_bit("wd_busy", busy, 1'b0);
    run_div = 1;
    start = 1; burst_len = 1;
    cycle("wd_restart");
    start = 0;
    check_bit("wd_stall_clr", stall_err, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle("wd_rerun");
      if (!m_busy) break;
    end
`else
    check_bit("nowd_busy", busy, 1'b1);
    check_bit("nowd_stall_err", stall_err, 1'b0);
    run_div = 1;
    do_reset();
    cycle("nowd_rst");
    reset_n = 1'b1;
`endif
    repeat (4) cycle("wd_tail");

    // Reset mid-burst once two edges are counted
    half = 3;
    while (m_busy || m_done) cycle("drain2");
    start = 1; burst_len = 8;
    cycle("mr_start");
    start = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_tick == 2) break;
      cycle("mr_run");
    end
    check_int("mr_tick_pre", int'(tick_cnt), 2);
    do_reset();
    check_bit("mr_busy0", busy, 1'b0);
    check_int("mr_tick0", int'(tick_cnt), 0);
    cycle("mr_in_rst");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("mr_prime");
      check_bit("mr_no_rise", rise_stb, 1'b0);
      check_bit("mr_no_fall", fall_stb, 1'b0);
    end
    repeat (30) cycle("mr_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
